// File: rtl/serial_nibble_adder_pkg.sv
// Shared state encoding and nibble width for the serial nibble add controller.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_nibble_adder.sv
// Sequences wide operands through an external 4-bit adder, one nibble per cycle; out_valid rises NIBBLES cycles after accept.
// in_ready only in IDLE; the result is held in DONE until out_ready.
module serial_nibble_adder
  import serial_add_pkg::*;
#(
  parameter int  NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        op_a,
  input  logic [W-1:0]        op_b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] adder_a,
  output logic [NIBBLE_W-1:0] adder_b,
  output logic                adder_cin,
  input  logic [NIBBLE_W:0]   adder_sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W:0]          result,
  output logic                busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;

  assign in_ready = !rst && (state == IDLE);
  assign busy     = (state != IDLE);

  // The adder is zero-latency: its result returns combinationally in the same cycle.
  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state == RUN) begin
      adder_a   = a_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];
      adder_b   = b_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];
      adder_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= op_a;
            b_reg <= op_b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result[NIBBLE_W*int'(idx) +: NIBBLE_W] <= adder_sum[NIBBLE_W-1:0];
          carry <= adder_sum[NIBBLE_W];
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            result[W] <= adder_sum[NIBBLE_W];
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed bench: a 4-nibble and a 1-nibble instance, each wired to a behavioural 4-bit adder.
module tb_serial_nibble_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 4-nibble instance
  logic        in_valid4, in_ready4, cin4, adder_cin4, out_valid4, out_ready4, busy4;
  logic [15:0] op_a4, op_b4;
  logic [3:0]  adder_a4, adder_b4;
  logic [4:0]  adder_sum4;
  logic [16:0] result4;

  // 1-nibble instance
  logic        in_valid1, in_ready1, cin1, adder_cin1, out_valid1, out_ready1, busy1;
  logic [3:0]  op_a1, op_b1;
  logic [3:0]  adder_a1, adder_b1;
  logic [4:0]  adder_sum1;
  logic [4:0]  result1;

  assign adder_sum4 = {1'b0, adder_a4} + {1'b0, adder_b4} + {4'b0, adder_cin4};
  assign adder_sum1 = {1'b0, adder_a1} + {1'b0, adder_b1} + {4'b0, adder_cin1};

  serial_nibble_adder #(.NIBBLES(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .cin(cin4),
    .adder_a(adder_a4), .adder_b(adder_b4), .adder_cin(adder_cin4),
    .adder_sum(adder_sum4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .busy(busy4)
  );

  serial_nibble_adder #(.NIBBLES(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .cin(cin1),
    .adder_a(adder_a1), .adder_b(adder_b1), .adder_cin(adder_cin1),
    .adder_sum(adder_sum1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation on the 4-nibble instance and walks it to DONE.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [16:0] exp_res, input logic [3:0] exp_cins);
    op_a4 = a; op_b4 = b; cin4 = c; in_valid4 = 1'b1;
    check("accept_in_ready", 32'(in_ready4), 32'd1);
    tick();
    in_valid4 = 1'b0;
    op_a4 = 16'hDEAD; op_b4 = 16'hBEEF; cin4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("adder_a",      32'(adder_a4),   32'(a[4*i +: 4]));
      check("adder_b",      32'(adder_b4),   32'(b[4*i +: 4]));
      check("adder_cin",    32'(adder_cin4), 32'(exp_cins[i]));
      check("run_out_valid", 32'(out_valid4), 32'd0);
      check("run_in_ready",  32'(in_ready4),  32'd0);
      tick();
    end
    check("done_out_valid", 32'(out_valid4), 32'd1);
    check("done_result",    32'(result4),    32'(exp_res));
    check("done_adder_a",   32'(adder_a4),   32'd0);
    check("done_busy",      32'(busy4),      32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b0; op_a4 = '0; op_b4 = '0; cin4 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_in_ready",  32'(in_ready4),  32'd0);
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_result",    32'(result4),    32'd0);
    check("rst_busy",      32'(busy4),      32'd0);
    check("rst_adder_a",   32'(adder_a4),   32'd0);
    check("rst_result1",   32'(result1),    32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready4), 32'd1);

    // 1234 + 4321 with out_ready also high in IDLE: only the input handshake applies
    out_ready4 = 1'b1;
    do_op(16'h1234, 16'h4321, 1'b0, 17'h05555, 4'b0000);
    tick();
    check("idle_out_valid", 32'(out_valid4), 32'd0);
    check("idle_in_ready",  32'(in_ready4),  32'd1);
    out_ready4 = 1'b0;

    // Carry ripples through every nibble
    do_op(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 4'b1110);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("idle2_busy", 32'(busy4), 32'd0);

    // All-ones plus carry-in
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 4'b1111);

    // Backpressure in DONE while in_valid toggles
    op_a4 = 16'h0101; op_b4 = 16'h0202;
    for (int i = 0; i < 5; i++) begin
      in_valid4 = ~in_valid4;
      tick();
      check("bp_out_valid", 32'(out_valid4), 32'd1);
      check("bp_in_ready",  32'(in_ready4),  32'd0);
      check("bp_result",    32'(result4),    32'h1FFFF);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("bp_release_out_valid", 32'(out_valid4), 32'd0);
    check("bp_release_in_ready",  32'(in_ready4),  32'd1);
    check("bp_release_busy",      32'(busy4),      32'd0);

    // Reset while at nibble index 2
    op_a4 = 16'h1234; op_b4 = 16'h4321; cin4 = 1'b0; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick(); tick();
    check("mid_adder_a_i2", 32'(adder_a4), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready4), 32'd0);
    tick();
    check("mid_rst_result",    32'(result4),    32'd0);
    check("mid_rst_out_valid", 32'(out_valid4), 32'd0);
    check("mid_rst_busy",      32'(busy4),      32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready_after", 32'(in_ready4), 32'd1);
    tick();
    check("mid_rst_stays_idle", 32'(busy4), 32'd0);

    // Single-nibble instance: 9 + 8 + 1
    op_a1 = 4'h9; op_b1 = 4'h8; cin1 = 1'b1; in_valid1 = 1'b1;
    check("n1_in_ready", 32'(in_ready1), 32'd1);
    tick();
    in_valid1 = 1'b0;
    check("n1_adder_a",   32'(adder_a1),   32'd9);
    check("n1_adder_b",   32'(adder_b1),   32'd8);
    check("n1_adder_cin", 32'(adder_cin1), 32'd1);
    check("n1_run_out_valid", 32'(out_valid1), 32'd0);
    tick();
    check("n1_out_valid", 32'(out_valid1), 32'd1);
    check("n1_result",    32'(result1),    32'h12);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("n1_idle_out_valid", 32'(out_valid1), 32'd0);
    check("n1_hold_result",    32'(result1),    32'h12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_nibble_adder.md
Name: serial_nibble_adder

Overview:
Multi-nibble serial add controller that sits directly upstream and downstream of the team's 4-bit ripple adder (5-bit result: sum[3:0], carry-out in sum[4]).
- Accepts two wide operands and a carry-in over a valid/ready handshake.
- Presents one nibble pair per cycle to the external 4-bit adder and captures its 5-bit result.
- Chains the carry-out into the next nibble and delivers the full-width sum plus final carry on an output handshake.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; legal range 1..16
W, 4*NIBBLES, operand width in bits (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
op_a  input  W  operand A
op_b  input  W  operand B
cin  input  1  carry-in for nibble 0
adder_a  output  4  nibble A to the external 4-bit adder
adder_b  output  4  nibble B to the external 4-bit adder
adder_cin  output  1  carry-in to the external 4-bit adder
adder_sum  input  5  result from the external adder; [3:0] sum, [4] carry-out
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W+1  {final carry, W-bit sum}
busy  output  1  high in RUN or DONE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the clk rising edge.
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, result=0, out_valid=0, nibble index=0, carry reg=0, operand regs=0.
  - in_ready=0 in any cycle where rst=1; otherwise in_ready=1 exactly when state=IDLE.
  - Reset asserted in RUN or DONE aborts the operation. The partial result is discarded and result reads 0 on the next cycle.
- IDLE:
  - adder_a/adder_b/adder_cin drive 0.
  - On in_valid&&in_ready, capture op_a, op_b, and cin into the carry reg; set index=0; go to RUN.
- RUN, one nibble per cycle, index i:
  - adder_a=A_reg[4i+3:4i], adder_b=B_reg[4i+3:4i], adder_cin=carry reg.
  - At the clock edge: result[4i+3:4i]<=adder_sum[3:0]; carry<=adder_sum[4]; i<=i+1.
  - When i=NIBBLES-1: also result[W]<=adder_sum[4]; go to DONE.
  - adder_sum is sampled as a combinational return path in the same cycle (zero-latency adder).
- DONE:
  - out_valid=1; result is stable; adder outputs drive 0.
  - On out_ready=1, go to IDLE and deassert out_valid.
  - result holds its value until the next acceptance overwrites it.
- Latency: out_valid rises exactly NIBBLES cycles after the acceptance edge.
- Throughput: at most one operation per NIBBLES+2 cycles. in_ready is low during RUN/DONE, and in_valid is ignored there.
- Carry chain: the captured cin is used only for nibble 0. Each later nibble uses the carry-out of the previous nibble.
- No overflow flag; the full W+1-bit result is exact.
- in_valid and out_ready in the same cycle in IDLE: only the input handshake applies (out_valid=0).
- Operand regs are not altered mid-operation even if op_a/op_b change.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - NIBBLE_W=4
- The nibble index counter (clog2(NIBBLES)-bit, wraps only via FSM reset to 0) is kept inline.
- No sub-module. The 4-bit adder stays external and is connected by the integrating top.

Test Plan:
- NIBBLES=4, op_a=16'h1234, op_b=16'h4321, cin=0 -> adder_a sequence 4,3,2,1; result=17'h05555; out_valid exactly 4 cycles after accept.
- op_a=16'hFFFF, op_b=16'h0001, cin=0 -> carry ripples through every nibble; adder_cin sequence 0,1,1,1; result=17'h10000.
- op_a=16'hFFFF, op_b=16'hFFFF, cin=1 -> result=17'h1FFFF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> result held at prior value, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
- Reset mid-RUN: assert rst at i=2 -> next cycle state=IDLE, result=0, out_valid=0, in_ready=1 once rst deasserts.
- NIBBLES=1: op_a=4'h9, op_b=4'h8, cin=1 -> result=5'h12 one cycle after accept.
